// File: rtl/column_move_collector_if.sv
// Bundle between the move collector, the per-square move FIFOs and the downstream
// consumer. The collector is the master; the square FIFOs and consumer form the slave side.
interface column_move_collector_if #(
   parameter int NUM_SQ = 8,
   parameter int MOVE_W = 19,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_SQ-1:0]        sq_done;
   logic [NUM_SQ-1:0]        sq_empty;
   logic [NUM_SQ*MOVE_W-1:0] sq_data;
   logic [NUM_SQ-1:0]        sq_rden;
   logic [MOVE_W-1:0]        out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [CW-1:0]            out_count;
   logic [CNT_W-1:0]         move_count;
   logic                     done;

   modport master (
      input  sq_done, sq_empty, sq_data, out_ready,
      output sq_rden, out_data, out_valid, out_count, move_count, done
   );

   modport slave (
      output sq_done, sq_empty, sq_data, out_ready,
      input  sq_rden, out_data, out_valid, out_count, move_count, done
   );
endinterface

// File: rtl/column_move_collector.sv
// Drains each finished square's move FIFO, one square at a time, into a show-ahead
// output FIFO, optionally dropping invalid moves; raises done once every square is drained.
module column_move_collector #(
   parameter int NUM_SQ         = 8,
   parameter int MOVE_W         = 19,
   parameter int DEPTH          = 64,
   parameter int ARB_MODE       = 0,
   parameter int FILTER_INVALID = 1,
   parameter int CNT_W          = 8
) (
   input logic                     clk,
   input logic                     reset,
   column_move_collector_if.master bus
);
   localparam int SEL_W = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic [1:0] {WAIT, DRAIN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [SEL_W-1:0]    sel_reg, sel_next;
   logic [SEL_W-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [SEL_W-1:0]    pick;
   logic                pick_valid;
   logic [NUM_SQ-1:0]   moved_reg, moved_next;
   logic [NUM_SQ-1:0]   rden_reg, rden_next;
   logic [NUM_SQ-1:0]   elig;
   logic                cap_reg;
   logic                rd_busy;
   logic                room;
   logic [MOVE_W-1:0]   sq_word [NUM_SQ];
   logic [MOVE_W-1:0]   cap_word;
   logic                push;
   logic                pop;
   logic [MOVE_W-1:0]   fifo_mem [DEPTH];
   logic [MOVE_W-1:0]   head_reg;
   logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg, rd_addr;
   logic [CW-1:0]       count_reg;
   logic [CNT_W-1:0]    move_count_reg;

   for (genvar gi = 0; gi < NUM_SQ; gi++) begin : g_word
      assign sq_word[gi] = bus.sq_data[gi*MOVE_W +: MOVE_W];
   end

   assign elig     = bus.sq_done & ~moved_reg;
   assign rd_busy  = |rden_reg;
   assign cap_word = sq_word[sel_reg];
   assign push     = cap_reg && !((FILTER_INVALID != 0) && cap_word[MOVE_W-1]);
   assign pop      = (count_reg != '0) && bus.out_ready;
   assign rd_addr  = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
   // Reserve space for the read on the wire and the word about to be captured.
   assign room     = (count_reg + CW'(rd_busy) + CW'(cap_reg)) < CW'(DEPTH);

   // Scan offsets from high to low so the smallest offset from the base wins.
   always_comb begin : arbiter
      logic [SEL_W-1:0] idx;
      idx        = '0;
      pick       = '0;
      pick_valid = 1'b0;
      for (int i = NUM_SQ - 1; i >= 0; i--) begin
         if (ARB_MODE == 1) idx = SEL_W'((int'(rr_ptr_reg) + i) % NUM_SQ);
         else               idx = SEL_W'(i);
         if (elig[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      sel_next    = sel_reg;
      rr_ptr_next = rr_ptr_reg;
      moved_next  = moved_reg;
      rden_next   = '0;
      case (state_reg)
         WAIT: begin
            if (&moved_reg) begin
               state_next = DONE;
            end else if (pick_valid) begin
               sel_next   = pick;
               state_next = DRAIN;
               if (ARB_MODE == 1)
                  rr_ptr_next = (pick == SEL_W'(NUM_SQ - 1)) ? '0 : pick + 1'b1;
            end
         end
         DRAIN: begin
            // Only one read outstanding, so sq_empty is current whenever rd_busy is low.
            if (!rd_busy && !cap_reg && bus.sq_empty[sel_reg]) begin
               moved_next[sel_reg] = 1'b1;
               state_next          = WAIT;
            end else if (!rd_busy && !bus.sq_empty[sel_reg] && room) begin
               rden_next[sel_reg] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= WAIT;
         sel_reg        <= '0;
         rr_ptr_reg     <= '0;
         moved_reg      <= '0;
         rden_reg       <= '0;
         cap_reg        <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         move_count_reg <= '0;
      end else begin
         state_reg  <= state_next;
         sel_reg    <= sel_next;
         rr_ptr_reg <= rr_ptr_next;
         moved_reg  <= moved_next;
         rden_reg   <= rden_next;
         cap_reg    <= rd_busy;
         rd_ptr_reg <= rd_addr;
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: ;
         endcase
         if (push && move_count_reg != '1) move_count_reg <= move_count_reg + 1'b1;
      end
   end

   // Registered-read storage; a word written to the next head slot is forwarded directly.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= cap_word;
      head_reg <= (push && wr_ptr_reg == rd_addr) ? cap_word : fifo_mem[rd_addr];
   end

   assign bus.sq_rden    = rden_reg;
   assign bus.out_data   = head_reg;
   assign bus.out_valid  = (count_reg != '0);
   assign bus.out_count  = count_reg;
   assign bus.move_count = move_count_reg;
   assign bus.done       = (state_reg == DONE);
endmodule

// File: tb/tb_column_move_collector.sv
// Directed bench: a fixed-priority/deep instance and a round-robin/shallow instance,
// each fed by behavioural square FIFOs, with scenario tasks checking expected values.
module tb_column_move_collector;
   localparam int W = 19;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   column_move_collector_if #(.NUM_SQ(8), .MOVE_W(W), .DEPTH(64), .CNT_W(8)) if_a ();
   column_move_collector_if #(.NUM_SQ(8), .MOVE_W(W), .DEPTH(4),  .CNT_W(8)) if_b ();

   column_move_collector #(.NUM_SQ(8), .MOVE_W(W), .DEPTH(64), .ARB_MODE(0),
                           .FILTER_INVALID(1), .CNT_W(8))
      dut_a (.clk(clk), .reset(reset), .bus(if_a.master));

   column_move_collector #(.NUM_SQ(8), .MOVE_W(W), .DEPTH(4), .ARB_MODE(1),
                           .FILTER_INVALID(1), .CNT_W(8))
      dut_b (.clk(clk), .reset(reset), .bus(if_b.master));

   // Behavioural square FIFOs: contents loaded by tasks while reset is low.
   logic [W-1:0] mem_a [8][16];
   logic [W-1:0] mem_b [8][16];
   int           len_a [8];
   int           len_b [8];
   int           rp_a  [8];
   int           rp_b  [8];
   logic [W-1:0] dat_a [8];
   logic [W-1:0] dat_b [8];

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (!reset) begin
            rp_a[i] <= 0;
            rp_b[i] <= 0;
         end else begin
            if (if_a.sq_rden[i]) begin
               dat_a[i] <= mem_a[i][rp_a[i] % 16];
               rp_a[i]  <= rp_a[i] + 1;
            end
            if (if_b.sq_rden[i]) begin
               dat_b[i] <= mem_b[i][rp_b[i] % 16];
               rp_b[i]  <= rp_b[i] + 1;
            end
         end
      end
   end

   always_comb begin
      if_a.sq_data  = '0;
      if_b.sq_data  = '0;
      if_a.sq_empty = '0;
      if_b.sq_empty = '0;
      for (int i = 0; i < 8; i++) begin
         if_a.sq_data[i*W +: W] = dat_a[i];
         if_b.sq_data[i*W +: W] = dat_b[i];
         if_a.sq_empty[i]       = (rp_a[i] >= len_a[i]);
         if_b.sq_empty[i]       = (rp_b[i] >= len_b[i]);
      end
   end

   // Monitor: popped words, square drain order, read-strobe statistics.
   logic [W-1:0] outq_a [$];
   logic [W-1:0] outq_b [$];
   int           ordq_a [$];
   int           ordq_b [$];
   int           rdcnt_a [8];
   int           rdcnt_b [8];
   int           multi_a, multi_b, fullrd_b;

   function automatic int first_set(input logic [7:0] v);
      int r;
      r = 0;
      for (int i = 7; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         outq_a.delete();
         outq_b.delete();
         ordq_a.delete();
         ordq_b.delete();
         for (int i = 0; i < 8; i++) begin
            rdcnt_a[i] <= 0;
            rdcnt_b[i] <= 0;
         end
         multi_a  <= 0;
         multi_b  <= 0;
         fullrd_b <= 0;
      end else begin
         if (if_a.out_valid && if_a.out_ready) outq_a.push_back(if_a.out_data);
         if (if_b.out_valid && if_b.out_ready) outq_b.push_back(if_b.out_data);
         if (if_a.sq_rden != 8'd0) begin
            if ($countones(if_a.sq_rden) != 1) multi_a <= multi_a + 1;
            rdcnt_a[first_set(if_a.sq_rden)] <= rdcnt_a[first_set(if_a.sq_rden)] + 1;
            if (ordq_a.size() == 0 || ordq_a[$] != first_set(if_a.sq_rden))
               ordq_a.push_back(first_set(if_a.sq_rden));
         end
         if (if_b.sq_rden != 8'd0) begin
            if ($countones(if_b.sq_rden) != 1) multi_b <= multi_b + 1;
            if (if_b.out_count == 3'd4) fullrd_b <= fullrd_b + 1;
            rdcnt_b[first_set(if_b.sq_rden)] <= rdcnt_b[first_set(if_b.sq_rden)] + 1;
            if (ordq_b.size() == 0 || ordq_b[$] != first_set(if_b.sq_rden))
               ordq_b.push_back(first_set(if_b.sq_rden));
         end
      end
   end

   task automatic enter_reset();
      @(negedge clk);
      reset = 1'b0;
      if_a.sq_done = 8'h00;
      if_b.sq_done = 8'h00;
      if_a.out_ready = 1'b1;
      if_b.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         len_a[i] = 0;
         len_b[i] = 0;
      end
   endtask

   task automatic leave_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      enter_reset();
      leave_reset();
      repeat (3) @(negedge clk);
      checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if_a.out_valid); end
      checks++; if (if_a.out_count !== 7'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", if_a.out_count); end
      checks++; if (if_a.move_count !== 8'd0) begin failures++; $display("FAIL reset_move_count got=%0d exp=0", if_a.move_count); end
      checks++; if (if_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", if_a.done); end
      checks++; if (if_a.sq_rden !== 8'h00) begin failures++; $display("FAIL reset_sq_rden got=%h exp=00", if_a.sq_rden); end
      $display("test_reset complete");
   endtask

   task automatic test_fixed_priority();
      int bad, n;
      enter_reset();
      for (int k = 0; k < 8; k++) begin
         len_a[k] = k + 1;
         for (int j = 0; j <= k; j++) mem_a[k][j] = W'(k * 16 + j);
      end
      if_a.sq_done = 8'hFF;
      leave_reset();
      for (int c = 0; c < 1000 && if_a.done !== 1'b1; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++; if (if_a.done !== 1'b1) begin failures++; $display("FAIL fixed_done got=%b exp=1", if_a.done); end
      bad = 0; n = 0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j <= k; j++) begin
            if (n >= outq_a.size() || outq_a[n] !== W'(k * 16 + j)) bad++;
            n++;
         end
      checks++; if (outq_a.size() != 36 || bad != 0) begin failures++; $display("FAIL fixed_words got_count=%0d bad=%0d exp_count=36 bad=0", outq_a.size(), bad); end
      checks++; if (ordq_a.size() != 8 || ordq_a[0] != 0 || ordq_a[3] != 3 || ordq_a[7] != 7) begin failures++; $display("FAIL fixed_order got=%p exp=0..7", ordq_a); end
      checks++; if (if_a.move_count !== 8'd36) begin failures++; $display("FAIL fixed_move_count got=%0d exp=36", if_a.move_count); end
      checks++; if (multi_a != 0) begin failures++; $display("FAIL fixed_onehot got_multi=%0d exp=0", multi_a); end
      $display("test_fixed_priority complete");
   endtask

   task automatic test_round_robin();
      enter_reset();
      len_b[2] = 3; len_b[5] = 2; len_b[0] = 2;
      for (int j = 0; j < 3; j++) begin
         mem_b[2][j] = W'(32'h200 + j);
         mem_b[5][j] = W'(32'h500 + j);
         mem_b[0][j] = W'(32'h000 + j);
      end
      if_b.sq_done = 8'b0010_0100;
      leave_reset();
      for (int c = 0; c < 100 && rdcnt_b[2] == 0; c++) @(negedge clk);
      if_b.sq_done = 8'b0010_0101;
      repeat (60) @(negedge clk);
      checks++; if (ordq_b.size() != 3 || ordq_b[0] != 2 || ordq_b[1] != 5 || ordq_b[2] != 0) begin failures++; $display("FAIL rr_order got=%p exp='{2,5,0}", ordq_b); end
      checks++; if (outq_b.size() != 7 || if_b.move_count !== 8'd7) begin failures++; $display("FAIL rr_words got=%0d/%0d exp=7/7", outq_b.size(), if_b.move_count); end
      $display("test_round_robin complete");
   endtask

   task automatic test_filter();
      enter_reset();
      len_a[3] = 4;
      mem_a[3][0] = 19'h00011;
      mem_a[3][1] = 19'h40022;
      mem_a[3][2] = 19'h00033;
      mem_a[3][3] = 19'h40044;
      if_a.sq_done = 8'hFF;
      leave_reset();
      for (int c = 0; c < 200 && if_a.done !== 1'b1; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++; if (if_a.done !== 1'b1) begin failures++; $display("FAIL filter_done got=%b exp=1", if_a.done); end
      checks++; if (outq_a.size() != 2 || outq_a[0] !== 19'h00011 || outq_a[1] !== 19'h00033) begin failures++; $display("FAIL filter_words got=%p exp='{11,33}", outq_a); end
      checks++; if (if_a.move_count !== 8'd2) begin failures++; $display("FAIL filter_move_count got=%0d exp=2", if_a.move_count); end
      $display("test_filter complete");
   endtask

   task automatic test_backpressure();
      int bad;
      enter_reset();
      len_b[0] = 10;
      for (int j = 0; j < 10; j++) mem_b[0][j] = W'(32'h0A0 + j);
      if_b.sq_done = 8'h01;
      if_b.out_ready = 1'b0;
      leave_reset();
      repeat (60) @(negedge clk);
      checks++; if (if_b.out_count !== 3'd4) begin failures++; $display("FAIL bp_full_count got=%0d exp=4", if_b.out_count); end
      checks++; if (rdcnt_b[0] != 4) begin failures++; $display("FAIL bp_reads got=%0d exp=4", rdcnt_b[0]); end
      checks++; if (fullrd_b != 0 || if_b.sq_rden !== 8'h00) begin failures++; $display("FAIL bp_rden_when_full got=%0d/%h exp=0/00", fullrd_b, if_b.sq_rden); end
      if_b.out_ready = 1'b1;
      for (int c = 0; c < 200 && outq_b.size() < 10; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      bad = 0;
      for (int j = 0; j < 10; j++) if (j >= outq_b.size() || outq_b[j] !== W'(32'h0A0 + j)) bad++;
      checks++; if (outq_b.size() != 10 || bad != 0) begin failures++; $display("FAIL bp_words got_count=%0d bad=%0d exp_count=10 bad=0", outq_b.size(), bad); end
      checks++; if (if_b.move_count !== 8'd10) begin failures++; $display("FAIL bp_move_count got=%0d exp=10", if_b.move_count); end
      checks++; if (if_b.done !== 1'b0) begin failures++; $display("FAIL bp_done_never got=%b exp=0", if_b.done); end
      $display("test_backpressure complete");
   endtask

   task automatic test_empty_square();
      int bad, n;
      enter_reset();
      for (int k = 0; k < 8; k++) begin
         len_a[k] = (k == 4) ? 0 : 1;
         mem_a[k][0] = W'(32'h300 + k);
      end
      if_a.sq_done = 8'hFF;
      leave_reset();
      for (int c = 0; c < 200 && if_a.done !== 1'b1; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++; if (if_a.done !== 1'b1) begin failures++; $display("FAIL empty_done got=%b exp=1", if_a.done); end
      checks++; if (rdcnt_a[4] != 0) begin failures++; $display("FAIL empty_no_rden got=%0d exp=0", rdcnt_a[4]); end
      bad = 0; n = 0;
      for (int k = 0; k < 8; k++)
         if (k != 4) begin
            if (n >= outq_a.size() || outq_a[n] !== W'(32'h300 + k)) bad++;
            n++;
         end
      checks++; if (outq_a.size() != 7 || bad != 0) begin failures++; $display("FAIL empty_words got_count=%0d bad=%0d exp_count=7 bad=0", outq_a.size(), bad); end
      $display("test_empty_square complete");
   endtask

   task automatic test_back_to_back_reset();
      int bad;
      enter_reset();
      len_a[0] = 10;
      for (int j = 0; j < 10; j++) mem_a[0][j] = W'(32'h100 + j);
      if_a.sq_done = 8'h01;
      if_a.out_ready = 1'b0;
      leave_reset();
      for (int c = 0; c < 100 && if_a.out_count !== 7'd3; c++) @(negedge clk);
      checks++; if (if_a.out_count !== 7'd3) begin failures++; $display("FAIL mid_fill got=%0d exp=3", if_a.out_count); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", if_a.out_valid); end
      checks++; if (if_a.out_count !== 7'd0) begin failures++; $display("FAIL mid_out_count got=%0d exp=0", if_a.out_count); end
      checks++; if (if_a.move_count !== 8'd0) begin failures++; $display("FAIL mid_move_count got=%0d exp=0", if_a.move_count); end
      checks++; if (if_a.done !== 1'b0 || if_a.sq_rden !== 8'h00) begin failures++; $display("FAIL mid_done_rden got=%b/%h exp=0/00", if_a.done, if_a.sq_rden); end
      if_a.sq_done = 8'hFF;
      if_a.out_ready = 1'b1;
      leave_reset();
      for (int c = 0; c < 300 && if_a.done !== 1'b1; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      bad = 0;
      for (int j = 0; j < 10; j++) if (j >= outq_a.size() || outq_a[j] !== W'(32'h100 + j)) bad++;
      checks++; if (outq_a.size() != 10 || bad != 0) begin failures++; $display("FAIL mid_redrain_words got_count=%0d bad=%0d exp_count=10 bad=0", outq_a.size(), bad); end
      checks++; if (if_a.move_count !== 8'd10 || if_a.done !== 1'b1) begin failures++; $display("FAIL mid_redrain_state got=%0d/%b exp=10/1", if_a.move_count, if_a.done); end
      $display("test_back_to_back_reset complete");
   endtask

   initial begin
      if_a.sq_done = 8'h00;
      if_b.sq_done = 8'h00;
      if_a.out_ready = 1'b1;
      if_b.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         len_a[i] = 0;
         len_b[i] = 0;
      end
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_filter();
      test_backpressure();
      test_empty_square();
      test_back_to_back_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
